divide: RTL and testbench

- Sequential 32-bit integer divider: the inverse counterpart of the team's iterative multiplier, sitting beside it in the ALU/HI-LO datapath to execute DIV/DIVU.
- Restoring long division on absolute values, one quotient bit per clock, followed by a sign-correction cycle.
- Start/end handshake matches the multiplier style: operands presented with a begin strobe, results qualified by an end pulse.

---
 rtl/divide.sv | 128 ++++++++++++
 tb/tb_divide.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/divide.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock, then a sign-fix cycle.
// Optional build macro: DIV_ZERO_FAST_EN (zero divisor skips the iteration phase).
module divide #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_busy,
    output logic             div_end
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dvd_shift;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] op1_raw;
    logic             sign1;
    logic             sign2;
    logic             dvs_zero;

    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_neg;
    logic [WIDTH-1:0] restored;
    logic [WIDTH-1:0] q_neg;
    logic [WIDTH-1:0] r_neg;

    // -2^(WIDTH-1) negates to itself; read as unsigned it is still the right magnitude.
    assign op1_neg = div_signed & div_op1[WIDTH-1];
    assign op2_neg = div_signed & div_op2[WIDTH-1];
    assign op1_abs = op1_neg ? -div_op1 : div_op1;
    assign op2_abs = op2_neg ? -div_op2 : div_op2;

    // The partial remainder only needs its extra top bit transiently, while shifted.
    assign shifted   = {part_rem, dvd_shift[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvs_abs};
    assign trial_neg = trial[WIDTH];
    assign restored  = {part_rem[WIDTH-2:0], dvd_shift[WIDTH-1]};

    assign q_neg = -dvd_shift;
    assign r_neg = -part_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            part_rem  <= '0;
            dvd_shift <= '0;
            dvs_abs   <= '0;
            op1_raw   <= '0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            dvs_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_busy  <= 1'b0;
            div_end   <= 1'b0;
        end else begin
            div_end <= 1'b0;
            case (state)
                IDLE: begin
                    div_busy <= 1'b0;
                    if (div_begin) begin
                        sign1     <= op1_neg;
                        sign2     <= op2_neg;
                        dvd_shift <= op1_abs;
                        dvs_abs   <= op2_abs;
                        op1_raw   <= div_op1;
                        dvs_zero  <= (div_op2 == '0);
                        part_rem  <= '0;
                        count     <= '0;
                        div_busy  <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        state     <= (div_op2 == '0) ? FIX : RUN;
`else
                        state     <= RUN;
`endif
                    end
                end
                RUN: begin
                    part_rem  <= trial_neg ? restored : trial[WIDTH-1:0];
                    dvd_shift <= {dvd_shift[WIDTH-2:0], ~trial_neg};
                    count     <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Zero divisor bypasses sign correction: all ones, dividend as given.
                    if (dvs_zero) begin
                        quotient  <= '1;
                        remainder <= op1_raw;
                    end else begin
                        quotient  <= (sign1 ^ sign2) ? q_neg : dvd_shift;
                        remainder <= sign1 ? r_neg : part_rem;
                    end
                    div_end <= 1'b1;
                    count   <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide: driver queues expected results, a negedge monitor checks each div_end.
module tb_divide;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_DZ = 1;
`else
    localparam int LAT_DZ = 33;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         div_begin;
    logic         div_signed;
    logic [W-1:0] div_op1;
    logic [W-1:0] div_op2;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_busy;
    logic         div_end;

    divide #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_begin  (div_begin),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_busy   (div_busy),
        .div_end    (div_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           start;
        int           lat;
    } exp_t;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_end = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (div_end) begin
            check("end_single_cycle", {31'b0, prev_end}, 32'd0);
            check("busy_at_end", {31'b0, div_busy}, 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_div_end at cycle %0d: got q=%h r=%h, expected no result", cyc, quotient, remainder);
            end else begin
                e = exp_q.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("latency", 32'(cyc - e.start), 32'(e.lat));
            end
        end
        prev_end <= div_end;
    end

    // Caller is at a negedge; the next posedge is the start edge.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input int lat, input bit push);
        exp_t e;
        div_signed = sgn;
        div_op1    = a;
        div_op2    = b;
        div_begin  = 1'b1;
        if (push) begin
            e.q = q; e.r = r; e.start = cyc + 1; e.lat = lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        div_begin  = 1'b0;
        div_op1    = ~a;
        div_op2    = b + 32'd5;
        div_signed = ~sgn;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!div_end && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!div_end) begin
            n_checks++;
            n_fail++;
            $display("FAIL div_end_timeout: got no div_end in %0d cycles, expected one", n);
        end
    endtask

    initial begin
        bit saw_end;
        vecs[0] = '{1'b1, 32'd7,        32'd2,        32'h00000003, 32'h00000001, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33};
        vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 33};
        vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h00000000, 32'hFFFFFFFF, 33};
        vecs[5] = '{1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, LAT_DZ};
        vecs[6] = '{1'b1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, LAT_DZ};
        vecs[7] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
        vecs[8] = '{1'b1, 32'hF0000000, 32'h00000000, 32'hFFFFFFFF, 32'hF0000000, LAT_DZ};
        vecs[9] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};

        rst        = 1'b1;
        div_begin  = 1'b0;
        div_signed = 1'b0;
        div_op1    = '0;
        div_op2    = '0;
        repeat (2) @(negedge clk);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_busy", {31'b0, div_busy}, 32'd0);
        check("reset_end", {31'b0, div_end}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat, 1'b1);
            wait_end();
        end

        // A second begin mid-operation must be ignored.
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 1'b1);
        repeat (5) @(negedge clk);
        div_op1   = 32'd50;
        div_op2   = 32'd5;
        div_begin = 1'b1;
        @(negedge clk);
        div_begin = 1'b0;
        wait_end();
        // Back-to-back start in the div_end cycle.
        issue(1'b0, 32'hDEADBEEF, 32'h00000100, 32'h00DEADBE, 32'h000000EF, 33, 1'b1);
        wait_end();

        // Reset mid-operation discards the operation.
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_busy", {31'b0, div_busy}, 32'd0);
        check("midrst_end", {31'b0, div_end}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        saw_end = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (div_end) saw_end = 1'b1;
        end
        check("no_end_after_reset", {31'b0, saw_end}, 32'd0);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
        wait_end();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
